// File: rtl/de_regfile_scoreboard_pkg.sv
// de_pkg: shared decode-stage constants and the writeback-to-decode bundle.
//   REGWORDS / REGNOBITS / DBITS : register file geometry.
//   MAXPEND / CNTBITS            : in-flight writer limit and counter width.
//   from_wb_to_de_t              : {rel, rel_regno, wr, regno, data}. The
//                                  release fields sit above the original
//                                  {wr, regno, data} layout.
package de_pkg;
  localparam int REGWORDS  = 32;
  localparam int REGNOBITS = 5;
  localparam int DBITS     = 32;
  localparam int CNTBITS   = 2;
  localparam logic [CNTBITS-1:0] MAXPEND = 2'd3;

  typedef struct packed {
    logic                 rel;
    logic [REGNOBITS-1:0] rel_regno;
    logic                 wr;
    logic [REGNOBITS-1:0] regno;
    logic [DBITS-1:0]     data;
  } from_wb_to_de_t;

  localparam int FROM_WB_TO_DE_WIDTH = $bits(from_wb_to_de_t);
endpackage

// File: rtl/de_regfile_scoreboard_if.sv
// Writeback-to-decode register-write bundle.
//   wb_wr_en/wb_regno/wb_data : register write, already qualified by WB valid.
//   wb_rel/wb_rel_regno       : scoreboard release for the retiring instruction.
// master = writeback stage (drives), slave = decode register file (receives).
interface de_regfile_scoreboard_if;
  import de_pkg::*;

  logic                 wb_wr_en;
  logic [REGNOBITS-1:0] wb_regno;
  logic [DBITS-1:0]     wb_data;
  logic                 wb_rel;
  logic [REGNOBITS-1:0] wb_rel_regno;

  modport master (output wb_wr_en, wb_regno, wb_data, wb_rel, wb_rel_regno);
  modport slave  (input  wb_wr_en, wb_regno, wb_data, wb_rel, wb_rel_regno);
endinterface

// File: rtl/de_regfile_scoreboard_chk.sv
// Protocol checker for the scoreboard release path.
//   clk, reset  : clock and synchronous reset (checks are off while in reset).
//   dec_vec     : per-register release requests this cycle.
//   nonzero_vec : per-register "has in-flight writers" flags.
// A release for a register with no in-flight writer means upstream lost track.
module de_regfile_scoreboard_chk
  import de_pkg::*;
(
  input logic                clk,
  input logic                reset,
  input logic [REGWORDS-1:0] dec_vec,
  input logic [REGWORDS-1:0] nonzero_vec
);
  a_release_of_idle_reg: assert property (@(posedge clk) disable iff (reset)
    (dec_vec & ~nonzero_vec) == {REGWORDS{1'b0}});
endmodule

// File: rtl/de_regfile_scoreboard_sb_counter.sv
// sb_counter: per-register pending-writer counter.
//   clk, reset : clock, synchronous active-high reset.
//   inc, dec   : a writer enters / leaves flight; both together cancel out.
//   cnt        : current number of in-flight writers (saturates at MAXPEND, floors at 0).
//   nonzero    : cnt != 0.
module sb_counter
  import de_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [CNTBITS-1:0] cnt,
  output logic               nonzero
);
  logic [CNTBITS-1:0] cnt_r;

  // Up/down count of in-flight writers; a release of an idle register holds at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNTBITS{1'b0}};
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (cnt_r != MAXPEND) cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          if (cnt_r != 2'd0) cnt_r <= cnt_r - 2'd1;
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign cnt     = cnt_r;
  assign nonzero = (cnt_r != 2'd0);
endmodule

// File: rtl/de_regfile_scoreboard.sv
// de_regfile_scoreboard: decode-stage register file with pending-write scoreboard.
//   clk, reset          : clock, synchronous active-high reset.
//   wb (slave)          : writeback register write and scoreboard release.
//   de_valid, de_fire   : instruction present in decode / advancing to AGEX.
//   de_use_rs1/2, de_rs1/2, de_wr, de_rd : operand usage of the decoding instruction.
//   rdata1, rdata2      : combinational operands with same-cycle writeback bypass.
//   stall               : decode must hold (source hazard or destination counter full).
//   busy_vec            : per-register "has in-flight writers" flags.
module de_regfile_scoreboard
  import de_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  de_regfile_scoreboard_if.slave   wb,
  input  logic                     de_valid,
  input  logic                     de_use_rs1,
  input  logic                     de_use_rs2,
  input  logic [REGNOBITS-1:0]     de_rs1,
  input  logic [REGNOBITS-1:0]     de_rs2,
  input  logic                     de_wr,
  input  logic [REGNOBITS-1:0]     de_rd,
  input  logic                     de_fire,
  output logic [DBITS-1:0]         rdata1,
  output logic [DBITS-1:0]         rdata2,
  output logic                     stall,
  output logic [REGWORDS-1:0]      busy_vec
);
  logic [DBITS-1:0]    regs_r [REGWORDS];
  logic [CNTBITS-1:0]  cnt_s  [REGWORDS];
  logic [REGWORDS-1:0] inc_s;
  logic [REGWORDS-1:0] dec_s;
  logic [REGWORDS-1:0] nonzero_s;
  logic                src1_hz_s;
  logic                src2_hz_s;
  logic                dst_full_s;

  // x0 reads as zero; a same-cycle write to the index is forwarded.
  function automatic logic [DBITS-1:0] read_port(
    input logic [REGNOBITS-1:0] idx,
    input logic                 wr_en,
    input logic [REGNOBITS-1:0] wr_regno,
    input logic [DBITS-1:0]     wr_data,
    input logic [DBITS-1:0]     stored
  );
    if (idx == {REGNOBITS{1'b0}}) return {DBITS{1'b0}};
    else if (wr_en && (wr_regno == idx)) return wr_data;
    else return stored;
  endfunction

  // Busy unless the only remaining writer is retiring now with its data on the bypass.
  function automatic logic busy_eff(
    input logic [CNTBITS-1:0]   cnt,
    input logic [REGNOBITS-1:0] idx,
    input logic                 rel,
    input logic [REGNOBITS-1:0] rel_regno,
    input logic                 wr_en,
    input logic [REGNOBITS-1:0] wr_regno
  );
    return (cnt != 2'd0) &&
           !((cnt == 2'd1) && rel && (rel_regno == idx) && wr_en && (wr_regno == idx));
  endfunction

  // Architectural register storage; x0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGWORDS; i++) regs_r[i] <= {DBITS{1'b0}};
    end else if (wb.wb_wr_en && (wb.wb_regno != {REGNOBITS{1'b0}})) begin
      regs_r[wb.wb_regno] <= wb.wb_data;
    end
  end

  // Per-register increment/decrement requests; x0 never participates.
  always_comb begin
    inc_s = {REGWORDS{1'b0}};
    dec_s = {REGWORDS{1'b0}};
    for (int r = 1; r < REGWORDS; r++) begin
      inc_s[r] = de_fire & de_wr & (de_rd == REGNOBITS'(r));
      dec_s[r] = wb.wb_rel & (wb.wb_rel_regno == REGNOBITS'(r));
    end
  end

  for (genvar r = 0; r < REGWORDS; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc_s[r]),
      .dec     (dec_s[r]),
      .cnt     (cnt_s[r]),
      .nonzero (nonzero_s[r])
    );
  end

  de_regfile_scoreboard_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .dec_vec     (dec_s),
    .nonzero_vec (nonzero_s)
  );

  // Operand read ports.
  always_comb begin
    rdata1 = read_port(de_rs1, wb.wb_wr_en, wb.wb_regno, wb.wb_data, regs_r[de_rs1]);
    rdata2 = read_port(de_rs2, wb.wb_wr_en, wb.wb_regno, wb.wb_data, regs_r[de_rs2]);
  end

  // Hazard detection; a release this cycle frees a slot for a full destination.
  always_comb begin
    src1_hz_s  = de_use_rs1 & busy_eff(cnt_s[de_rs1], de_rs1, wb.wb_rel,
                                       wb.wb_rel_regno, wb.wb_wr_en, wb.wb_regno);
    src2_hz_s  = de_use_rs2 & busy_eff(cnt_s[de_rs2], de_rs2, wb.wb_rel,
                                       wb.wb_rel_regno, wb.wb_wr_en, wb.wb_regno);
    dst_full_s = de_wr & (cnt_s[de_rd] == MAXPEND) & ~dec_s[de_rd];
    if (de_valid) begin
      stall = src1_hz_s | src2_hz_s | dst_full_s;
    end else begin
      stall = 1'b0;
    end
  end

  assign busy_vec = nonzero_s;
endmodule

// File: tb/tb_de_regfile_scoreboard.sv
module tb_de_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid, de_use_rs1, de_use_rs2, de_wr, de_fire;
  logic [4:0]  de_rs1, de_rs2, de_rd;
  logic [31:0] rdata1, rdata2, busy_vec;
  logic        stall;

  de_regfile_scoreboard_if wb_if ();

  de_regfile_scoreboard dut (
    .clk(clk), .reset(reset), .wb(wb_if),
    .de_valid(de_valid), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_wr(de_wr), .de_rd(de_rd),
    .de_fire(de_fire), .rdata1(rdata1), .rdata2(rdata2),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Reference model: register values and number of in-flight writers per register.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_if.wb_wr_en && wb_if.wb_regno == idx) return wb_if.wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit hazard(input logic [4:0] idx);
    bit last_retires;
    last_retires = (m_cnt[idx] == 1) && wb_if.wb_rel && (wb_if.wb_rel_regno == idx)
                   && wb_if.wb_wr_en && (wb_if.wb_regno == idx);
    return (m_cnt[idx] > 0) && !last_retires;
  endfunction

  function automatic bit exp_stall();
    bit full;
    full = de_wr && (m_cnt[de_rd] >= 3) &&
           !(wb_if.wb_rel && wb_if.wb_rel_regno == de_rd && de_rd != 5'd0);
    return de_valid && ((de_use_rs1 && hazard(de_rs1)) ||
                        (de_use_rs2 && hazard(de_rs2)) || full);
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = (m_cnt[r] > 0);
    return v;
  endfunction

  // Model state update at each clock edge.
  always @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      int nv;
      if (reset) begin
        m_regs[r] <= 32'd0;
        m_cnt[r]  <= 0;
      end else begin
        nv = m_cnt[r];
        if (r != 0 && de_fire && de_wr && de_rd == 5'(r)) nv = nv + 1;
        if (r != 0 && wb_if.wb_rel && wb_if.wb_rel_regno == 5'(r)) nv = nv - 1;
        if (nv < 0) nv = 0;
        if (nv > 3) nv = 3;
        m_cnt[r] <= nv;
        if (r != 0 && wb_if.wb_wr_en && wb_if.wb_regno == 5'(r)) m_regs[r] <= wb_if.wb_data;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("cyc_rdata1", rdata1, exp_read(de_rs1));
      check("cyc_rdata2", rdata2, exp_read(de_rs2));
      check("cyc_stall", {31'd0, stall}, {31'd0, exp_stall()});
      check("cyc_busy_vec", busy_vec, exp_busy());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_if.wb_wr_en = 1'b0; wb_if.wb_regno = 5'd0; wb_if.wb_data = 32'd0;
    wb_if.wb_rel = 1'b0;   wb_if.wb_rel_regno = 5'd0;
    de_valid = 1'b0; de_use_rs1 = 1'b0; de_use_rs2 = 1'b0; de_wr = 1'b0; de_fire = 1'b0;
    de_rs1 = 5'd0; de_rs2 = 5'd0; de_rd = 5'd0;
  endtask

  task automatic fire_wr(input logic [4:0] rd);
    idle();
    de_valid = 1'b1; de_wr = 1'b1; de_rd = rd; de_fire = 1'b1;
    tick();
  endtask

  task automatic read1(input logic [4:0] rs);
    idle();
    de_valid = 1'b1; de_use_rs1 = 1'b1; de_rs1 = rs;
  endtask

  task automatic wb_put(input logic [4:0] r, input logic [31:0] d, input bit rel);
    wb_if.wb_wr_en = 1'b1; wb_if.wb_regno = r; wb_if.wb_data = d;
    wb_if.wb_rel = rel;    wb_if.wb_rel_regno = r;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // After reset: everything clear.
    idle(); de_valid = 1'b1; de_use_rs1 = 1'b1; de_use_rs2 = 1'b1; de_rs1 = 5'd5; de_rs2 = 5'd0;
    #2;
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", busy_vec, 32'd0);
    tick();

    // Single writer to x3, then retire with bypass.
    fire_wr(5'd3);
    read1(5'd3); #2;
    check("x3_hazard_stall", {31'd0, stall}, 32'd1);
    wb_put(5'd3, 32'hDEADBEEF, 1'b1); #2;
    check("x3_retire_stall", {31'd0, stall}, 32'd0);
    check("x3_bypass", rdata1, 32'hDEADBEEF);
    tick();
    read1(5'd3); #2;
    check("x3_busy_clear", busy_vec, 32'd0);
    check("x3_stored", rdata1, 32'hDEADBEEF);
    tick();

    // Three writers to x7 saturate its counter.
    fire_wr(5'd7); fire_wr(5'd7); fire_wr(5'd7);
    idle(); de_valid = 1'b1; de_wr = 1'b1; de_rd = 5'd7; #2;
    check("x7_busy", busy_vec, 32'h0000_0080);
    check("x7_full_stall", {31'd0, stall}, 32'd1);
    wb_if.wb_rel = 1'b1; wb_if.wb_rel_regno = 5'd7; #2;
    check("x7_rel_unstall", {31'd0, stall}, 32'd0);
    de_fire = 1'b1;
    tick();
    idle(); de_valid = 1'b1; de_wr = 1'b1; de_rd = 5'd7; #2;
    check("x7_still_full", {31'd0, stall}, 32'd1);

    // x0 is immutable and never busy.
    idle(); wb_put(5'd0, 32'h0000_1234, 1'b0); de_rs1 = 5'd0; #2;
    check("x0_bypass_zero", rdata1, 32'd0);
    tick();
    idle(); #2;
    check("x0_stored_zero", rdata1, 32'd0);
    fire_wr(5'd0);
    idle(); #2;
    check("x0_not_busy", {31'd0, busy_vec[0]}, 32'd0);

    // Two writers to x9 retire one at a time.
    fire_wr(5'd9); fire_wr(5'd9);
    read1(5'd9); wb_put(5'd9, 32'h11, 1'b1); #2;
    check("x9_first_retire_stall", {31'd0, stall}, 32'd1);
    tick();
    read1(5'd9); wb_put(5'd9, 32'h22, 1'b1); #2;
    check("x9_last_retire_stall", {31'd0, stall}, 32'd0);
    check("x9_last_bypass", rdata1, 32'h22);
    tick();
    read1(5'd9); #2;
    check("x9_stored", rdata1, 32'h22);

    // Reset with x4 pending discards everything.
    fire_wr(5'd4); fire_wr(5'd4);
    idle(); #2;
    check("x4_pending", {31'd0, busy_vec[4]}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read1(5'd4); #2;
    check("x4_rst_busy", busy_vec, 32'd0);
    check("x4_rst_rdata", rdata1, 32'd0);
    check("x4_rst_stall", {31'd0, stall}, 32'd0);
    tick();

    // Randomized protocol-legal traffic on a small register window.
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] cand;
      idle();
      reset = ($urandom_range(0, 399) == 0);
      wb_if.wb_wr_en = $urandom_range(0, 1);
      wb_if.wb_regno = 5'($urandom_range(0, 7));
      wb_if.wb_data  = $urandom;
      cand = 5'($urandom_range(1, 7));
      if (m_cnt[cand] > 0 && $urandom_range(0, 2) != 0) begin
        wb_if.wb_rel = 1'b1;
        wb_if.wb_rel_regno = cand;
        if ($urandom_range(0, 3) != 0) begin
          wb_if.wb_wr_en = 1'b1;
          wb_if.wb_regno = cand;
        end
      end else begin
        wb_if.wb_rel_regno = 5'($urandom_range(0, 7));
      end
      de_valid   = ($urandom_range(0, 7) != 0);
      de_use_rs1 = $urandom_range(0, 1);
      de_use_rs2 = $urandom_range(0, 1);
      de_rs1     = 5'($urandom_range(0, 7));
      de_rs2     = 5'($urandom_range(0, 7));
      de_wr      = $urandom_range(0, 1);
      de_rd      = 5'($urandom_range(0, 7));
      de_fire    = de_valid && !exp_stall() && !reset && ($urandom_range(0, 3) != 0);
      tick();
    end

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
